// File: rtl/uart_pkg.sv
// Shared UART constants: oversample rate, ack byte, rx state encoding, transmitter retry limits.
// The ACK_* states exist only when UART_RX_ACK_EN is defined.
package uart_pkg;

   localparam logic [7:0]  ACK_BYTE         = 8'hCC;
   localparam int unsigned OS_RATE          = 16;
   localparam int unsigned OS_CNT_W         = $clog2(OS_RATE);
   localparam int unsigned OS_MID           = OS_RATE / 2 - 1;
   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned BIT_CNT_W        = $clog2(DATA_BITS);
   localparam int unsigned ACK_RETRY_MAX    = 3;
   localparam int unsigned ACK_TIMEOUT_BITS = 24;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
`ifdef UART_RX_ACK_EN
      ACK_START,
      ACK_DATA,
      ACK_STOP,
`endif
      WAIT_IDLE
   } rx_state_t;

   // Oversample divider, floored and never below one clock
   function automatic int unsigned os_div(input int unsigned clk_hz, input int unsigned baud);
      int unsigned d;
      d = clk_hz / (baud * OS_RATE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte signals between a UART peer (master) and uart_rx (slave).
interface uart_rx_if;

   logic       rx;
   logic       ack_out;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       rx_busy;

   modport slave (
      input  rx,
      output ack_out,
      output data_out,
      output data_valid,
      output frame_err,
      output rx_busy
   );

   modport master (
      output rx,
      input  ack_out,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  rx_busy
   );

endinterface

// File: rtl/uart_os_tick_gen.sv
// Free-running divider producing a one-clock os_tick every CLK_HZ/(BAUD*16) clocks.
module uart_os_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 19_200
) (
   input  logic clk,
   input  logic reset,
   output logic os_tick
);

   localparam int unsigned DIV   = os_div(CLK_HZ, BAUD);
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         os_tick <= 1'b0;
      end else if (cnt == CNT_W'(DIV - 1)) begin
         cnt     <= '0;
         os_tick <= 1'b1;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         os_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 MSB-first UART receiver with 16x oversampling; define UART_RX_ACK_EN to return
// an 8'hCC acknowledgement frame on ack_out after each good byte.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 19_200
) (
   input  logic       clk,
   input  logic       reset,
   uart_rx_if.slave   bus
);

   logic                 rx_meta, rx_sync, rx_prev;
   logic                 os_tick;
   logic                 rx_fall, os_last, os_mid, bit_last;

   rx_state_t            state, state_nxt;
   logic [OS_CNT_W-1:0]  os_cnt, os_cnt_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [7:0]           shreg, shreg_nxt;
   logic [7:0]           data_r, data_nxt;
   logic                 valid_r, valid_nxt;
   logic                 ferr_r, ferr_nxt;
   logic                 busy_r, busy_nxt;
`ifdef UART_RX_ACK_EN
   logic                 stop_ok, stop_ok_nxt;
   logic                 ack_r, ack_nxt;
`endif

   uart_os_tick_gen #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_os_tick (
      .clk     (clk),
      .reset   (reset),
      .os_tick (os_tick)
   );

   // Two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall  = rx_prev & ~rx_sync;
   assign os_last  = (os_cnt == OS_CNT_W'(OS_RATE - 1));
   assign os_mid   = (os_cnt == OS_CNT_W'(OS_MID));
   assign bit_last = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
`ifdef UART_RX_ACK_EN
         stop_ok <= 1'b0;
         ack_r   <= 1'b1;
`endif
      end else begin
         state   <= state_nxt;
         os_cnt  <= os_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         data_r  <= data_nxt;
         valid_r <= valid_nxt;
         ferr_r  <= ferr_nxt;
         busy_r  <= busy_nxt;
`ifdef UART_RX_ACK_EN
         stop_ok <= stop_ok_nxt;
         ack_r   <= ack_nxt;
`endif
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt   = state;
      os_cnt_nxt  = os_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      data_nxt    = data_r;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
`ifdef UART_RX_ACK_EN
      stop_ok_nxt = stop_ok;
`endif

      case (state)
         IDLE: begin
            if (rx_fall) begin
               state_nxt  = START;
               os_cnt_nxt = '0;
            end
         end

         START: begin
            if (os_tick) begin
               if (os_mid) begin
                  os_cnt_nxt  = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = rx_sync ? IDLE : DATA;
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end

         DATA: begin
            if (os_tick) begin
               if (os_last) begin
                  os_cnt_nxt = '0;
                  shreg_nxt  = {shreg[6:0], rx_sync};
                  if (bit_last) begin
                     bit_cnt_nxt = '0;
                     state_nxt   = STOP;
                  end else begin
                     bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  end
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end

         STOP: begin
            if (os_tick) begin
`ifdef UART_RX_ACK_EN
               // After a good stop sample, hold off to the stop-bit boundary before acking
               if (stop_ok) begin
                  if (os_mid) begin
                     os_cnt_nxt  = '0;
                     stop_ok_nxt = 1'b0;
                     state_nxt   = ACK_START;
                  end else begin
                     os_cnt_nxt = os_cnt + OS_CNT_W'(1);
                  end
               end else
`endif
               if (os_last) begin
                  os_cnt_nxt = '0;
                  if (rx_sync) begin
                     data_nxt  = shreg;
                     valid_nxt = 1'b1;
`ifdef UART_RX_ACK_EN
                     stop_ok_nxt = 1'b1;
`else
                     state_nxt = IDLE;
`endif
                  end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = WAIT_IDLE;
                  end
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end

         WAIT_IDLE: begin
            if (rx_sync) begin
               state_nxt = IDLE;
            end
         end

`ifdef UART_RX_ACK_EN
         ACK_START: begin
            if (os_tick) begin
               if (os_last) begin
                  os_cnt_nxt  = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = ACK_DATA;
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end

         ACK_DATA: begin
            if (os_tick) begin
               if (os_last) begin
                  os_cnt_nxt = '0;
                  if (bit_last) begin
                     bit_cnt_nxt = '0;
                     state_nxt   = ACK_STOP;
                  end else begin
                     bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  end
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end

         ACK_STOP: begin
            if (os_tick) begin
               if (os_last) begin
                  os_cnt_nxt = '0;
                  state_nxt  = IDLE;
               end else begin
                  os_cnt_nxt = os_cnt + OS_CNT_W'(1);
               end
            end
         end
`endif

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs derived from the next state so they switch on the same edge as the state
      busy_nxt = (state_nxt != IDLE);
`ifdef UART_RX_ACK_EN
      ack_nxt = 1'b1;
      if (state_nxt == ACK_START) begin
         ack_nxt = 1'b0;
      end else if (state_nxt == ACK_DATA) begin
         ack_nxt = ACK_BYTE[~bit_cnt_nxt];
      end
`endif
   end

   assign bus.data_out   = data_r;
   assign bus.data_valid = valid_r;
   assign bus.frame_err  = ferr_r;
   assign bus.rx_busy    = busy_r;
`ifdef UART_RX_ACK_EN
   assign bus.ack_out    = ack_r;
`else
   assign bus.ack_out    = 1'b1;
`endif

endmodule
